vga_sprite_pipe: RTL

// Pixel stage directly downstream of the 640x480 timing core. Consumes its de/hsync/vsync/Sx/Sy and

---
 rtl/vga_sprite_pipe.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sprite_pipe.sv
// ---------------------------------------------------------------------------
// vga_sprite_pipe
// Pixel stage that sits behind the 640x480 timing core. It draws a 16x16
// sprite from a writable 256x12 bitmap RAM over a background and returns
// 4:4:4 RGB. Once every SPEED_DIV frames the sprite steps by STEP pixels on
// each axis and bounces off the screen edges. de/hsync/vsync are delayed
// by two clocks so that they line up with the two-stage colour pipeline.
//
// Optional feature macro: VGA_CHECKER_BG_EN
//   defined     : background is a 32x32 checkerboard of BG_COLOUR / ~BG_COLOUR
//   not defined : background is BG_COLOUR everywhere
//
// Ports
//   i_VGA_CLOCK          pixel clock
//   i_rst_n              synchronous active-low reset
//   i_de                 draw enable from the timing core
//   i_hsync, i_vsync     syncs from the timing core, active low
//   i_Sx, i_Sy           timing core horizontal / vertical counters
//   i_spr_we             bitmap write strobe
//   i_spr_addr           bitmap address {row[3:0], col[3:0]}
//   i_spr_wdata          bitmap RGB, 12'h000 is transparent
//   o_de, o_hsync,
//   o_vsync              inputs delayed by two clocks
//   o_r, o_g, o_b        colour, forced to 0 while o_de is low
//
// Motion FSM
//   state     | meaning
//   ST_WAIT   | idle, counting vsync falling edges
//   ST_STEP_X | apply one horizontal step / bounce
//   ST_STEP_Y | apply one vertical step / bounce
// ---------------------------------------------------------------------------
module vga_sprite_pipe #(
    parameter int          H_ACT_START = 47,
    parameter int          V_ACT_START = 32,
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480,
    parameter int          SPR_X0      = 100,
    parameter int          SPR_Y0      = 60,
    parameter int          STEP        = 2,
    parameter int          SPEED_DIV   = 1,
    parameter logic [11:0] BG_COLOUR   = 12'h124
) (
    input  logic        i_VGA_CLOCK,
    input  logic        i_rst_n,
    input  logic        i_de,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [9:0]  i_Sx,
    input  logic [9:0]  i_Sy,
    input  logic        i_spr_we,
    input  logic [7:0]  i_spr_addr,
    input  logic [11:0] i_spr_wdata,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [3:0]  o_r,
    output logic [3:0]  o_g,
    output logic [3:0]  o_b
);

    localparam logic [9:0] H0       = 10'(H_ACT_START);
    localparam logic [9:0] V0       = 10'(V_ACT_START);
    localparam logic [9:0] X_MAX    = 10'(H_RES - 16);
    localparam logic [9:0] Y_MAX    = 10'(V_RES - 16);
    localparam logic [9:0] STEP_V   = 10'(STEP);
    localparam logic [9:0] X_RST    = 10'(SPR_X0);
    localparam logic [9:0] Y_RST    = 10'(SPR_Y0);
    localparam logic [7:0] DIV_LAST = 8'(SPEED_DIV - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_STEP_X = 2'd1,
        ST_STEP_Y = 2'd2
    } state_t;

    // sprite position and motion state
    state_t      r_state;
    logic [9:0]  r_spr_x;
    logic [9:0]  r_spr_y;
    logic        r_dir_x;   // 1 = moving +x
    logic        r_dir_y;   // 1 = moving +y
    logic [7:0]  r_div;
    logic        r_vsync_d;
    logic        w_vs_fall;

    // stage 1
    logic [9:0]  w_px;
    logic [9:0]  w_py;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic        w_hit;
    logic [11:0] w_bg;
    logic        r_s1_de;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic        r_s1_hit;
    logic [7:0]  r_s1_addr;
    logic [11:0] r_s1_bg;

    // stage 2
    logic        r_s2_de;
    logic        r_s2_hs;
    logic        r_s2_vs;
    logic        r_s2_hit;
    logic [11:0] r_s2_bg;
    logic [11:0] r_ram_q;
    logic [11:0] w_colour;

    logic [11:0] r_mem [256];

    // Offsets are unsigned: pixels left of / above the sprite wrap to a
    // large value and fall outside the 0..15 window.
    assign w_px  = i_Sx - H0;
    assign w_py  = i_Sy - V0;
    assign w_dx  = w_px - r_spr_x;
    assign w_dy  = w_py - r_spr_y;
    assign w_hit = (w_dx < 10'd16) && (w_dy < 10'd16);

`ifdef VGA_CHECKER_BG_EN
    assign w_bg = (w_px[5] ^ w_py[5]) ? ~BG_COLOUR : BG_COLOUR;
`else
    assign w_bg = BG_COLOUR;
`endif

    always_ff @(posedge i_VGA_CLOCK) begin
        if (!i_rst_n) begin
            r_s1_de   <= 1'b0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
            r_s1_hit  <= 1'b0;
            r_s1_addr <= 8'h00;
            r_s1_bg   <= 12'h000;
            r_s2_de   <= 1'b0;
            r_s2_hs   <= 1'b1;
            r_s2_vs   <= 1'b1;
            r_s2_hit  <= 1'b0;
            r_s2_bg   <= 12'h000;
        end else begin
            r_s1_de   <= i_de;
            r_s1_hs   <= i_hsync;
            r_s1_vs   <= i_vsync;
            r_s1_hit  <= w_hit;
            r_s1_addr <= {w_dy[3:0], w_dx[3:0]};
            r_s1_bg   <= w_bg;
            r_s2_de   <= r_s1_de;
            r_s2_hs   <= r_s1_hs;
            r_s2_vs   <= r_s1_vs;
            r_s2_hit  <= r_s1_hit;
            r_s2_bg   <= r_s1_bg;
        end
    end

    // Bitmap RAM: not reset. A read and write to the same address in the
    // same cycle returns the old contents.
    always_ff @(posedge i_VGA_CLOCK) begin
        if (i_spr_we) begin
            r_mem[i_spr_addr] <= i_spr_wdata;
        end
        r_ram_q <= r_mem[r_s1_addr];
    end

    assign w_colour = (r_s2_hit && (r_ram_q != 12'h000)) ? r_ram_q : r_s2_bg;

    assign o_de    = r_s2_de;
    assign o_hsync = r_s2_hs;
    assign o_vsync = r_s2_vs;
    assign o_r     = r_s2_de ? w_colour[11:8] : 4'h0;
    assign o_g     = r_s2_de ? w_colour[7:4]  : 4'h0;
    assign o_b     = r_s2_de ? w_colour[3:0]  : 4'h0;

    assign w_vs_fall = r_vsync_d & ~i_vsync;

    // Motion only reacts to vsync, so the position never changes while
    // active video is being drawn.
    always_ff @(posedge i_VGA_CLOCK) begin
        if (!i_rst_n) begin
            r_state   <= ST_WAIT;
            r_spr_x   <= X_RST;
            r_spr_y   <= Y_RST;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_div     <= 8'd0;
            r_vsync_d <= 1'b1;
        end else begin
            r_vsync_d <= i_vsync;
            case (r_state)
                ST_WAIT: begin
                    if (w_vs_fall) begin
                        if (r_div == DIV_LAST) begin
                            r_div   <= 8'd0;
                            r_state <= ST_STEP_X;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                end
                ST_STEP_X: begin
                    if (r_dir_x) begin
                        if (r_spr_x + STEP_V >= X_MAX) begin
                            r_spr_x <= X_MAX;
                            r_dir_x <= 1'b0;
                        end else begin
                            r_spr_x <= r_spr_x + STEP_V;
                        end
                    end else begin
                        if (r_spr_x <= STEP_V) begin
                            r_spr_x <= 10'd0;
                            r_dir_x <= 1'b1;
                        end else begin
                            r_spr_x <= r_spr_x - STEP_V;
                        end
                    end
                    r_state <= ST_STEP_Y;
                end
                ST_STEP_Y: begin
                    if (r_dir_y) begin
                        if (r_spr_y + STEP_V >= Y_MAX) begin
                            r_spr_y <= Y_MAX;
                            r_dir_y <= 1'b0;
                        end else begin
                            r_spr_y <= r_spr_y + STEP_V;
                        end
                    end else begin
                        if (r_spr_y <= STEP_V) begin
                            r_spr_y <= 10'd0;
                            r_dir_y <= 1'b1;
                        end else begin
                            r_spr_y <= r_spr_y - STEP_V;
                        end
                    end
                    r_state <= ST_WAIT;
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

endmodule
